// File: rtl/add_seq16.sv
// rtl/add_seq16.sv - multi-word add/subtract sequencer driving one shared 16-bit adder
//
// Purpose:
//   Latches two WORDS x 16-bit operands and streams them, least significant
//   word first, through an external combinational 16-bit ripple-carry adder
//   (fulladder16). The carry is registered between words and the full-width
//   result is assembled in o_sum. Subtraction is a + ~b + 1.
//
// Optional feature macro: ADD_SEQ_OVF_EN
//   Defined   -> adds o_overflow (signed two's-complement overflow of o_sum).
//   Undefined -> no overflow port or logic.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst          synchronous reset, active-high
//   i_start        request a new operation (accepted only while idle)
//   i_sub          0: a+b+c_in, 1: a-b (c_in ignored)
//   i_a, i_b       W-bit operands, sampled on accept
//   i_c_in         initial carry for add, sampled on accept
//   o_busy         high while an operation is in progress
//   o_done         one-cycle pulse when o_sum/o_c_out are valid
//   o_sum          W-bit result, held until the next accept
//   o_c_out        carry out of the top word (sub: 1 = no borrow)
//   o_adder_a/b    16-bit operands to the shared adder
//   o_adder_cin    carry into the shared adder
//   i_adder_sum    16-bit sum from the shared adder
//   i_adder_cout   carry out from the shared adder
//   o_overflow     (ADD_SEQ_OVF_EN only) signed overflow, held with o_sum

module add_seq16 #(
  parameter int WORDS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_sub,
  input  logic [16*WORDS-1:0]   i_a,
  input  logic [16*WORDS-1:0]   i_b,
  input  logic                  i_c_in,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [16*WORDS-1:0]   o_sum,
  output logic                  o_c_out,
  output logic [15:0]           o_adder_a,
  output logic [15:0]           o_adder_b,
  output logic                  o_adder_cin,
  input  logic [15:0]           i_adder_sum,
  input  logic                  i_adder_cout
`ifdef ADD_SEQ_OVF_EN
  ,
  output logic                  o_overflow
`endif
);

  localparam int W  = 16 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic            r_carry;
  logic            r_c_out;
  logic [IW-1:0]   r_idx;

  logic [IW+3:0]   w_base;
  logic            w_last;

  // Bit offset of the current word: idx * 16.
  assign w_base = {r_idx, 4'b0000};
  assign w_last = (r_idx == IW'(WORDS - 1));

  // ---------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM next state and adder-facing outputs
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    o_adder_a    = 16'h0000;
    o_adder_b    = 16'h0000;
    o_adder_cin  = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        o_adder_a   = r_a[w_base +: 16];
        o_adder_b   = r_b[w_base +: 16];
        o_adder_cin = r_carry;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        o_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath: operand latch, word-by-word result assembly, carry chain
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_c_out <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_a     <= i_a;
            // Subtraction is folded into the add: invert b, force carry-in.
            r_b     <= i_sub ? ~i_b : i_b;
            r_carry <= i_sub | i_c_in;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          r_sum[w_base +: 16] <= i_adder_sum;
          r_carry             <= i_adder_cout;
          if (w_last) begin
            r_c_out <= i_adder_cout;
            // Clear rather than increment so idx never leaves 0..WORDS-1.
            r_idx   <= '0;
          end else begin
            r_idx   <= r_idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef ADD_SEQ_OVF_EN
  logic r_overflow;
  logic w_cin15;

  // Carry into the top bit, recovered from the top-bit sum: a ^ b ^ cin = s.
  assign w_cin15 = r_a[W-1] ^ r_b[W-1] ^ i_adder_sum[15];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_overflow <= 1'b0;
    end else if ((r_state == S_RUN) && w_last) begin
      r_overflow <= w_cin15 ^ i_adder_cout;
    end
  end

  assign o_overflow = r_overflow;
`endif

  assign o_busy  = (r_state != S_IDLE);
  assign o_sum   = r_sum;
  assign o_c_out = r_c_out;

endmodule

// File: tb/tb_add_seq16.sv
// tb/tb_add_seq16.sv - self-checking bench for add_seq16 with a behavioural adder and reference model

module tb_add_seq16;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;
  localparam int CW    = W + 1;

  logic           clk;
  logic           rst;
  logic           start;
  logic           sub;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           c_in;
  logic           busy;
  logic           done;
  logic [W-1:0]   sum;
  logic           c_out;
  logic [15:0]    adder_a;
  logic [15:0]    adder_b;
  logic           adder_cin;
  logic [15:0]    adder_sum;
  logic           adder_cout;
`ifdef ADD_SEQ_OVF_EN
  logic           overflow;
`endif

  int tests = 0;
  int fails = 0;

  add_seq16 #(.WORDS(WORDS)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_sub        (sub),
    .i_a          (a),
    .i_b          (b),
    .i_c_in       (c_in),
    .o_busy       (busy),
    .o_done       (done),
    .o_sum        (sum),
    .o_c_out      (c_out),
    .o_adder_a    (adder_a),
    .o_adder_b    (adder_b),
    .o_adder_cin  (adder_cin),
    .i_adder_sum  (adder_sum),
    .i_adder_cout (adder_cout)
`ifdef ADD_SEQ_OVF_EN
    ,
    .o_overflow   (overflow)
`endif
  );

  // Stand-in for fulladder16: purely combinational 16-bit add.
  logic [16:0] add_full;
  assign add_full   = {1'b0, adder_a} + {1'b0, adder_b} + {16'd0, adder_cin};
  assign adder_sum  = add_full[15:0];
  assign adder_cout = add_full[16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {overflow, c_out, sum} from plain W-bit arithmetic.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                          input logic rcin, input logic rsub);
    logic [W-1:0] s;
    logic         c;
    logic         ov;
    if (rsub) begin
      s  = ra - rb;
      c  = (ra >= rb);
      ov = (ra[W-1] != rb[W-1]) && (s[W-1] != ra[W-1]);
    end else begin
      {c, s} = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rcin};
      ov = (ra[W-1] == rb[W-1]) && (s[W-1] != ra[W-1]);
    end
    return {ov, c, s};
  endfunction

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tcin, input logic tsub, input string tag);
    int           cyc;
    int           busy_cnt;
    logic         got;
    logic [W+1:0] exp;
    exp = ref_op(ta, tb, tcin, tsub);
    @(negedge clk);
    a = ta; b = tb; c_in = tcin; sub = tsub; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; busy_cnt = 0; got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
      if (done) got = 1'b1;
    end
    chk({tag, "_latency"}, CW'(cyc), CW'(WORDS + 1));
    chk({tag, "_busy_cycles"}, CW'(busy_cnt), CW'(WORDS + 1));
    chk({tag, "_sum"}, CW'(sum), CW'(exp[W-1:0]));
    chk({tag, "_c_out"}, CW'(c_out), CW'(exp[W]));
`ifdef ADD_SEQ_OVF_EN
    chk({tag, "_overflow"}, CW'(overflow), CW'(exp[W+1]));
`endif
    @(negedge clk);
    chk({tag, "_done_pulse_width"}, CW'(done), CW'(0));
    chk({tag, "_idle_adder_a"}, CW'(adder_a), CW'(0));
    chk({tag, "_sum_held"}, CW'(sum), CW'(exp[W-1:0]));
  endtask

  initial begin
    int dn;
    int bz;
    logic         got;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; c_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", CW'(busy), CW'(0));
    chk("rst_done", CW'(done), CW'(0));
    chk("rst_sum", CW'(sum), CW'(0));
    chk("rst_c_out", CW'(c_out), CW'(0));
    chk("rst_adder_ab", CW'({adder_a, adder_b, adder_cin}), CW'(0));
`ifdef ADD_SEQ_OVF_EN
    chk("rst_overflow", CW'(overflow), CW'(0));
`endif
    rst = 1'b0;

    // Directed operations
    run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, "carry_w0");
    chk("carry_w0_const", CW'({c_out, sum}), CW'({1'b0, 64'h0000_0000_0001_0000}));
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, "ripple_all");
    chk("ripple_all_const", CW'({c_out, sum}), CW'({1'b1, 64'h0}));
    run_op(64'd5, 64'd7, 1'b0, 1'b1, "sub_neg");
    chk("sub_neg_const", CW'({c_out, sum}), CW'({1'b0, 64'hFFFF_FFFF_FFFF_FFFE}));
    run_op(64'd5, 64'd7, 1'b1, 1'b1, "sub_neg_cin1");
    chk("sub_neg_cin1_const", CW'({c_out, sum}), CW'({1'b0, 64'hFFFF_FFFF_FFFF_FFFE}));
    run_op(64'd7, 64'd5, 1'b1, 1'b1, "sub_pos");
    chk("sub_pos_const", CW'({c_out, sum}), CW'({1'b1, 64'd2}));
    run_op(64'd7, 64'd5, 1'b0, 1'b1, "sub_pos_cin0");
    chk("sub_pos_cin0_const", CW'({c_out, sum}), CW'({1'b1, 64'd2}));
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, "ovf_pos");
    chk("ovf_pos_const", CW'({c_out, sum}), CW'({1'b0, 64'h8000_0000_0000_0000}));
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, "ovf_none");
    chk("ovf_none_c_out", CW'(c_out), CW'(1));

    // start during RUN and during DONE must be ignored
    @(negedge clk);
    a = 64'd1; b = 64'd1; c_in = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 64'h10; b = 64'h10; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dn = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        dn++;
        start = 1'b1;
      end
    end
    chk("busy_start_done_seen", CW'(got), CW'(1));
    @(posedge clk);
    #1 start = 1'b0;
    bz = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) dn++;
      if (busy) bz++;
    end
    chk("busy_start_sum", CW'(sum), CW'(2));
    chk("busy_start_single_done", CW'(dn), CW'(1));
    chk("busy_start_no_restart", CW'(bz), CW'(0));

    // Reset in the second RUN cycle discards the operation
    @(negedge clk);
    a = 64'h1234; b = 64'h1111; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", CW'(busy), CW'(0));
    chk("mid_rst_done", CW'(done), CW'(0));
    chk("mid_rst_sum", CW'(sum), CW'(0));
    chk("mid_rst_c_out", CW'(c_out), CW'(0));
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("mid_rst_no_done", CW'(dn), CW'(0));
    run_op(64'd3, 64'd4, 1'b0, 1'b0, "after_rst");
    chk("after_rst_const", CW'(sum), CW'(7));

    // Randomised operations against the reference model
    for (int i = 0; i < 20; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 5 == 0) rb = ~ra;
      run_op(ra, rb, 1'($urandom), 1'($urandom), $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
